timer_seq_ctrl: RTL and testbench
=================================

Name: timer_seq_ctrl

Overview:
- Avalon-MM master that sequences one interval-timer slave (16-bit data, 3-bit word address, registered readdata, no waitrequest).
- Programs the period, starts the timer in continuous or one-shot mode, services its level IRQ by clearing status, and stops it on request.
- Presents a simple start/stop/tick interface to local logic, so that logic never drives timer registers directly.

Parameters:
- TICK_CNT_W, 16, width of the timeout counter output.
- DW, 16, Avalon data width; fixed by the timer slave, not overridable in practice.
- AW, 3, Avalon word address width.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset.
- cfg_period  in  32  timer period, sampled on an accepted start.
- cfg_continuous  in  1  1 = continuous, 0 = one-shot; sampled with cfg_period.
- cfg_start  in  1  start pulse.
- cfg_stop  in  1  stop pulse.
- busy  out  1  high whenever the FSM is not IDLE.
- cfg_err  out  1  one-cycle pulse when a start is rejected.
- tick  out  1  one-cycle pulse per serviced timeout.
- tick_count  out  TICK_CNT_W  serviced-timeout count.
- timer_irq  in  1  timer interrupt, level, synchronous to clk.
- avm_chipselect  out  1
- avm_write  out  1
- avm_read  out  1
- avm_address  out  AW
- avm_writedata  out  DW
- avm_readdata  in  DW  valid one cycle after the read address is presented.

Behaviour:
- Clocking/reset: one clock; reset is synchronous and active-high.
- Reset values: all outputs 0, FSM = IDLE, shadow period and mode = 0. Reset mid-operation aborts the sequence immediately with no bus cycle in flight. The timer has its own reset.
- Bus rules:
  - Each access lasts exactly one cycle with avm_chipselect = 1 and exactly one of avm_write/avm_read = 1.
  - Outside an access, all avm_* outputs are 0.
- States and transitions:
  - IDLE: on cfg_start, latch cfg_period/cfg_continuous.
    - Period 0: reject, pulse cfg_err, stay IDLE.
    - Otherwise go to WR_PL.
  - WR_PL: write addr 2 = period[15:0] → WR_PH.
  - WR_PH: write addr 3 = period[31:16] → WR_CTL.
  - WR_CTL: write addr 1 = 0x7 if continuous, else 0x5 (START | CONT | ITO) → RUN.
    - Start latency: first bus write occurs the cycle after cfg_start; the control write occurs on the 3rd cycle.
  - RUN: evaluated in priority order.
    1. timer_irq = 1 → CLR.
    2. cfg_stop → STOP.
    3. Otherwise hold.
    - cfg_start in any non-IDLE state is ignored, without cfg_err.
  - CLR: write addr 0 = 0x0000; pulse tick; increment tick_count, wrapping from all-ones to 0.
    - Pending stop → STOP.
    - Else continuous → RUN.
    - Else one-shot → IDLE.
    - IRQ deasserts the cycle after the CLR write, so RUN never double-counts.
  - STOP: write addr 1 = 0x8 (STOP, ITO = 0) → IDLE.
- cfg_stop handling:
  - cfg_stop asserted in WR_PL..WR_CTL or CLR sets a pending-stop flag. It is honoured on the next RUN entry or directly from CLR; the flag is cleared in STOP.
  - cfg_stop and timer_irq in the same RUN cycle: CLR first (tick counted), then STOP.
  - cfg_stop in IDLE: no effect.
- tick_count is not cleared by start; it is cleared only by reset.

Optional Feature:
- Macro: TIMER_SEQ_SNAPSHOT_EN.
- With the macro defined:
  - Adds input snap_req (1), output snap_valid (1, pulse) and output snap_value (32, reset 0).
  - snap_req in RUN with timer_irq = 0 triggers the sequence below, then returns to RUN.
    - SNAP_WR: write addr 4 (data 0x0000).
    - SNAP_RL: read addr 4.
    - SNAP_RH: read addr 5; capture avm_readdata into snap_value[15:0].
    - SNAP_CAP: capture avm_readdata into snap_value[31:16]; pulse snap_valid.
  - snap_req outside RUN is dropped.
  - IRQ arriving mid-snapshot is serviced on return to RUN; being level-sensitive, it is not lost.
- Without the macro: ports and states are absent, and snap_req behaviour does not exist.

Decomposition:
- Shared package timer_seq_pkg:
  - Register addresses: STATUS 0, CONTROL 1, PERIODL 2, PERIODH 3, SNAPL 4, SNAPH 5.
  - Control bit positions: ITO 0, CONT 1, START 2, STOP 3.
  - State enum.
- No sub-module: single FSM plus counter.

Test Plan:
- Start with period 0x0000_0031, continuous: cycles 1–3 write addr2 = 0x0031, addr3 = 0x0000, addr1 = 0x0007. busy = 1 and all avm_* outputs = 0 afterwards.
- In RUN, assert timer_irq until the addr0 write: exactly one addr0 write of 0x0000, tick = 1 for one cycle, tick_count 0 → 1, FSM back in RUN.
- One-shot start (control 0x0005), then IRQ: CLR, then busy = 0; a following cfg_start is accepted.
- cfg_stop and timer_irq in the same cycle: addr0 write with a tick, then addr1 = 0x0008, then IDLE.
- cfg_start with period 0: cfg_err pulses and no bus activity. Preload 0xFFFF ticks, one more IRQ: tick_count wraps to 0.
- Reset asserted during WR_PH: next cycle all outputs 0, FSM in IDLE. With TIMER_SEQ_SNAPSHOT_EN, snap_req with readdata 0x1234 then 0x0002 gives snap_value = 0x0002_1234 and snap_valid for one cycle.

Source files
------------

// File: rtl/timer_seq_pkg.sv
// timer_seq_pkg: shared definitions for the interval-timer sequencer.
//   - timer register word addresses and control-register bit positions
//   - FSM state enum (snapshot states only with TIMER_SEQ_SNAPSHOT_EN)
//   - Avalon request payload struct plus small builder helpers
package timer_seq_pkg;

  localparam int unsigned AVM_AW = 3;
  localparam int unsigned AVM_DW = 16;

  // Timer register map (word addresses)
  localparam logic [AVM_AW-1:0] ADDR_STATUS  = AVM_AW'(0);
  localparam logic [AVM_AW-1:0] ADDR_CONTROL = AVM_AW'(1);
  localparam logic [AVM_AW-1:0] ADDR_PERIODL = AVM_AW'(2);
  localparam logic [AVM_AW-1:0] ADDR_PERIODH = AVM_AW'(3);
  localparam logic [AVM_AW-1:0] ADDR_SNAPL   = AVM_AW'(4);
  localparam logic [AVM_AW-1:0] ADDR_SNAPH   = AVM_AW'(5);

  // Control register bit positions
  localparam int unsigned CTL_ITO   = 0;
  localparam int unsigned CTL_CONT  = 1;
  localparam int unsigned CTL_START = 2;
  localparam int unsigned CTL_STOP  = 3;

  localparam logic [AVM_DW-1:0] CTL_STOP_WORD = AVM_DW'(1) << CTL_STOP;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_WR_PL    = 4'd1,
    ST_WR_PH    = 4'd2,
    ST_WR_CTL   = 4'd3,
    ST_RUN      = 4'd4,
    ST_CLR      = 4'd5,
    ST_STOP     = 4'd6
`ifdef TIMER_SEQ_SNAPSHOT_EN
    ,
    ST_SNAP_WR  = 4'd7,
    ST_SNAP_RL  = 4'd8,
    ST_SNAP_RH  = 4'd9,
    ST_SNAP_CAP = 4'd10
`endif
  } state_t;

  // One Avalon access; all-zero means bus idle
  typedef struct packed {
    logic              cs;
    logic              wr;
    logic              rd;
    logic [AVM_AW-1:0] addr;
    logic [AVM_DW-1:0] data;
  } avm_req_t;

  function automatic avm_req_t wr_req(input logic [AVM_AW-1:0] a,
                                      input logic [AVM_DW-1:0] d);
    avm_req_t r;
    r.cs   = 1'b1;
    r.wr   = 1'b1;
    r.rd   = 1'b0;
    r.addr = a;
    r.data = d;
    return r;
  endfunction

  function automatic avm_req_t rd_req(input logic [AVM_AW-1:0] a);
    avm_req_t r;
    r.cs   = 1'b1;
    r.wr   = 1'b0;
    r.rd   = 1'b1;
    r.addr = a;
    r.data = '0;
    return r;
  endfunction

  // START | ITO, plus CONT for continuous mode
  function automatic logic [AVM_DW-1:0] ctl_start_word(input logic cont);
    logic [AVM_DW-1:0] w;
    w            = '0;
    w[CTL_START] = 1'b1;
    w[CTL_ITO]   = 1'b1;
    w[CTL_CONT]  = cont;
    return w;
  endfunction

endpackage

// File: rtl/timer_seq_ctrl.sv
// timer_seq_ctrl: Avalon-MM master sequencing one interval timer.
//   Programs period, starts (continuous/one-shot), clears status on IRQ,
//   stops on request. Optional TIMER_SEQ_SNAPSHOT_EN adds a counter snapshot.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   cfg_period/cfg_continuous  configuration, sampled on accepted start
//   cfg_start/cfg_stop         control pulses
//   busy, cfg_err, tick        status; cfg_err/tick are one-cycle pulses
//   tick_count                 serviced-timeout count (wraps)
//   timer_irq                  timer level interrupt
//   avm_*                      Avalon-MM master to the timer slave
//   snap_req/snap_valid/snap_value  snapshot interface (macro only)
module timer_seq_ctrl
  import timer_seq_pkg::*;
#(
  parameter int unsigned TICK_CNT_W = 16,
  parameter int unsigned DW         = 16,
  parameter int unsigned AW         = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           cfg_period,
  input  logic                  cfg_continuous,
  input  logic                  cfg_start,
  input  logic                  cfg_stop,
  output logic                  busy,
  output logic                  cfg_err,
  output logic                  tick,
  output logic [TICK_CNT_W-1:0] tick_count,
  input  logic                  timer_irq,
  output logic                  avm_chipselect,
  output logic                  avm_write,
  output logic                  avm_read,
  output logic [AW-1:0]         avm_address,
  output logic [DW-1:0]         avm_writedata,
  input  logic [DW-1:0]         avm_readdata
`ifdef TIMER_SEQ_SNAPSHOT_EN
  ,
  input  logic                  snap_req,
  output logic                  snap_valid,
  output logic [31:0]           snap_value
`endif
);

  state_t      state;
  avm_req_t    bus_q;
  logic [31:0] period_q;
  logic        cont_q;
  logic        stop_pend;

  // Bus outputs come straight from the registered request
  assign avm_chipselect = bus_q.cs;
  assign avm_write      = bus_q.wr;
  assign avm_read       = bus_q.rd;
  assign avm_address    = AW'(bus_q.addr);
  assign avm_writedata  = DW'(bus_q.data);

`ifndef TIMER_SEQ_SNAPSHOT_EN
  logic unused_rdata;
  assign unused_rdata = ^avm_readdata;
`endif

  // Sequencer: outputs are registered for the state being entered, so the
  // access belonging to a state is on the bus while that state is current.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      bus_q      <= '0;
      period_q   <= '0;
      cont_q     <= 1'b0;
      stop_pend  <= 1'b0;
      busy       <= 1'b0;
      cfg_err    <= 1'b0;
      tick       <= 1'b0;
      tick_count <= '0;
`ifdef TIMER_SEQ_SNAPSHOT_EN
      snap_valid <= 1'b0;
      snap_value <= '0;
`endif
    end else begin
      bus_q   <= '0;
      cfg_err <= 1'b0;
      tick    <= 1'b0;
`ifdef TIMER_SEQ_SNAPSHOT_EN
      snap_valid <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (cfg_start) begin
            period_q <= cfg_period;
            cont_q   <= cfg_continuous;
            if (cfg_period == 32'd0) begin
              cfg_err <= 1'b1;
            end else begin
              state <= ST_WR_PL;
              busy  <= 1'b1;
              bus_q <= wr_req(ADDR_PERIODL, cfg_period[15:0]);
            end
          end
        end
        ST_WR_PL: begin
          if (cfg_stop) stop_pend <= 1'b1;
          state <= ST_WR_PH;
          bus_q <= wr_req(ADDR_PERIODH, period_q[31:16]);
        end
        ST_WR_PH: begin
          if (cfg_stop) stop_pend <= 1'b1;
          state <= ST_WR_CTL;
          bus_q <= wr_req(ADDR_CONTROL, ctl_start_word(cont_q));
        end
        ST_WR_CTL: begin
          if (cfg_stop) stop_pend <= 1'b1;
          state <= ST_RUN;
        end
        ST_RUN: begin
          if (timer_irq) begin
            // A stop arriving with the IRQ is remembered and taken after CLR
            if (cfg_stop) stop_pend <= 1'b1;
            state      <= ST_CLR;
            bus_q      <= wr_req(ADDR_STATUS, '0);
            tick       <= 1'b1;
            tick_count <= tick_count + TICK_CNT_W'(1);
          end else if (cfg_stop || stop_pend) begin
            state <= ST_STOP;
            bus_q <= wr_req(ADDR_CONTROL, CTL_STOP_WORD);
`ifdef TIMER_SEQ_SNAPSHOT_EN
          end else if (snap_req) begin
            state <= ST_SNAP_WR;
            bus_q <= wr_req(ADDR_SNAPL, '0);
`endif
          end
        end
        ST_CLR: begin
          if (stop_pend || cfg_stop) begin
            state <= ST_STOP;
            bus_q <= wr_req(ADDR_CONTROL, CTL_STOP_WORD);
          end else if (cont_q) begin
            state <= ST_RUN;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_STOP: begin
          stop_pend <= 1'b0;
          state     <= ST_IDLE;
          busy      <= 1'b0;
        end
`ifdef TIMER_SEQ_SNAPSHOT_EN
        ST_SNAP_WR: begin
          if (cfg_stop) stop_pend <= 1'b1;
          state <= ST_SNAP_RL;
          bus_q <= rd_req(ADDR_SNAPL);
        end
        ST_SNAP_RL: begin
          if (cfg_stop) stop_pend <= 1'b1;
          state <= ST_SNAP_RH;
          bus_q <= rd_req(ADDR_SNAPH);
        end
        // readdata lags the read address by one cycle
        ST_SNAP_RH: begin
          if (cfg_stop) stop_pend <= 1'b1;
          snap_value[15:0] <= 16'(avm_readdata);
          state            <= ST_SNAP_CAP;
        end
        ST_SNAP_CAP: begin
          if (cfg_stop) stop_pend <= 1'b1;
          snap_value[31:16] <= 16'(avm_readdata);
          snap_valid        <= 1'b1;
          state             <= ST_RUN;
        end
`endif
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_seq_ctrl.sv
// tb_timer_seq_ctrl: directed self-checking bench for timer_seq_ctrl.
// Tick counter is built 4 bits wide so the wrap case is reachable quickly.
module tb_timer_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cfg_period;
  logic        cfg_continuous;
  logic        cfg_start;
  logic        cfg_stop;
  logic        busy;
  logic        cfg_err;
  logic        tick;
  logic [3:0]  tick_count;
  logic        timer_irq;
  logic        avm_chipselect;
  logic        avm_write;
  logic        avm_read;
  logic [2:0]  avm_address;
  logic [15:0] avm_writedata;
  logic [15:0] avm_readdata;
`ifdef TIMER_SEQ_SNAPSHOT_EN
  logic        snap_req;
  logic        snap_valid;
  logic [31:0] snap_value;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  timer_seq_ctrl #(.TICK_CNT_W(4), .DW(16), .AW(3)) dut (
    .clk            (clk),
    .reset          (reset),
    .cfg_period     (cfg_period),
    .cfg_continuous (cfg_continuous),
    .cfg_start      (cfg_start),
    .cfg_stop       (cfg_stop),
    .busy           (busy),
    .cfg_err        (cfg_err),
    .tick           (tick),
    .tick_count     (tick_count),
    .timer_irq      (timer_irq),
    .avm_chipselect (avm_chipselect),
    .avm_write      (avm_write),
    .avm_read       (avm_read),
    .avm_address    (avm_address),
    .avm_writedata  (avm_writedata),
    .avm_readdata   (avm_readdata)
`ifdef TIMER_SEQ_SNAPSHOT_EN
    ,
    .snap_req       (snap_req),
    .snap_valid     (snap_valid),
    .snap_value     (snap_value)
`endif
  );

  // Advance one clock; inputs change and outputs are observed at negedge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Whole bus as one word: {cs, wr, rd, addr, data}
  task automatic chk_bus(input string tag, input logic wr, input logic rd,
                         input logic [2:0] a, input logic [15:0] d);
    logic [31:0] obs;
    logic [31:0] exp;
    obs = 32'({avm_chipselect, avm_write, avm_read, avm_address, avm_writedata});
    exp = 32'({wr | rd, wr, rd, a, d});
    chk(tag, obs, exp);
  endtask

  task automatic start(input logic [31:0] p, input logic cont);
    cfg_period     = p;
    cfg_continuous = cont;
    cfg_start      = 1'b1;
    step();
    cfg_start      = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    cfg_period     = '0;
    cfg_continuous = 1'b0;
    cfg_start      = 1'b0;
    cfg_stop       = 1'b0;
    timer_irq      = 1'b0;
    avm_readdata   = '0;
`ifdef TIMER_SEQ_SNAPSHOT_EN
    snap_req       = 1'b0;
`endif
    @(negedge clk);
    step();
    step();
    reset = 1'b0;

    // Reset state
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(cfg_err), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_count", 32'(tick_count), 32'd0);
    chk_bus("rst_bus", 1'b0, 1'b0, 3'd0, 16'h0000);
`ifdef TIMER_SEQ_SNAPSHOT_EN
    chk("rst_snap", snap_value, 32'h0);
`endif

    // Stop in IDLE does nothing
    cfg_stop = 1'b1;
    step();
    cfg_stop = 1'b0;
    chk("idle_stop_busy", 32'(busy), 32'd0);
    chk_bus("idle_stop_bus", 1'b0, 1'b0, 3'd0, 16'h0000);

    // Continuous start, period 0x31
    start(32'h0000_0031, 1'b1);
    chk_bus("cont_pl", 1'b1, 1'b0, 3'd2, 16'h0031);
    chk("cont_busy", 32'(busy), 32'd1);
    step();
    chk_bus("cont_ph", 1'b1, 1'b0, 3'd3, 16'h0000);
    step();
    chk_bus("cont_ctl", 1'b1, 1'b0, 3'd1, 16'h0007);
    step();
    chk_bus("run_idle_bus", 1'b0, 1'b0, 3'd0, 16'h0000);
    chk("run_busy", 32'(busy), 32'd1);

    // Start while busy is ignored, no cfg_err
    start(32'h0, 1'b0);
    chk("busy_start_err", 32'(cfg_err), 32'd0);
    chk_bus("busy_start_bus", 1'b0, 1'b0, 3'd0, 16'h0000);

    // IRQ service
    timer_irq = 1'b1;
    step();
    timer_irq = 1'b0;
    chk_bus("clr_wr", 1'b1, 1'b0, 3'd0, 16'h0000);
    chk("clr_tick", 32'(tick), 32'd1);
    chk("clr_count", 32'(tick_count), 32'd1);
    step();
    chk("clr_tick_off", 32'(tick), 32'd0);
    chk_bus("clr_back_run", 1'b0, 1'b0, 3'd0, 16'h0000);
    chk("clr_busy", 32'(busy), 32'd1);
    chk("clr_count_hold", 32'(tick_count), 32'd1);

    // Stop and IRQ together: CLR with tick, then STOP, then IDLE
    timer_irq = 1'b1;
    cfg_stop  = 1'b1;
    step();
    timer_irq = 1'b0;
    cfg_stop  = 1'b0;
    chk_bus("both_clr", 1'b1, 1'b0, 3'd0, 16'h0000);
    chk("both_tick", 32'(tick), 32'd1);
    chk("both_count", 32'(tick_count), 32'd2);
    step();
    chk_bus("both_stop", 1'b1, 1'b0, 3'd1, 16'h0008);
    chk("both_stop_tick", 32'(tick), 32'd0);
    step();
    chk_bus("both_idle_bus", 1'b0, 1'b0, 3'd0, 16'h0000);
    chk("both_idle_busy", 32'(busy), 32'd0);

    // One-shot start, IRQ returns to IDLE
    start(32'h0001_0002, 1'b0);
    chk_bus("os_pl", 1'b1, 1'b0, 3'd2, 16'h0002);
    step();
    chk_bus("os_ph", 1'b1, 1'b0, 3'd3, 16'h0001);
    step();
    chk_bus("os_ctl", 1'b1, 1'b0, 3'd1, 16'h0005);
    step();
    timer_irq = 1'b1;
    step();
    timer_irq = 1'b0;
    chk_bus("os_clr", 1'b1, 1'b0, 3'd0, 16'h0000);
    chk("os_count", 32'(tick_count), 32'd3);
    step();
    chk("os_idle_busy", 32'(busy), 32'd0);

    // Restart accepted; stop during programming is held and taken in RUN
    start(32'h0000_0005, 1'b1);
    chk_bus("re_pl", 1'b1, 1'b0, 3'd2, 16'h0005);
    chk("re_busy", 32'(busy), 32'd1);
    cfg_stop = 1'b1;
    step();
    cfg_stop = 1'b0;
    chk_bus("re_ph", 1'b1, 1'b0, 3'd3, 16'h0000);
    step();
    chk_bus("re_ctl", 1'b1, 1'b0, 3'd1, 16'h0007);
    step();
    chk_bus("re_run", 1'b0, 1'b0, 3'd0, 16'h0000);
    step();
    chk_bus("pend_stop", 1'b1, 1'b0, 3'd1, 16'h0008);
    step();
    chk("pend_idle", 32'(busy), 32'd0);

    // Period 0 rejected
    start(32'h0, 1'b1);
    chk("p0_err", 32'(cfg_err), 32'd1);
    chk("p0_busy", 32'(busy), 32'd0);
    chk_bus("p0_bus", 1'b0, 1'b0, 3'd0, 16'h0000);
    step();
    chk("p0_err_pulse", 32'(cfg_err), 32'd0);
    chk_bus("p0_bus2", 1'b0, 1'b0, 3'd0, 16'h0000);

    // Counter wrap: run to all-ones, then one more IRQ
    start(32'h0000_0010, 1'b1);
    step();
    step();
    step();
    timer_irq = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      step();
    end
    chk("wrap_full", 32'(tick_count), 32'd15);
    step();
    timer_irq = 1'b0;
    chk("wrap_tick", 32'(tick), 32'd1);
    chk("wrap_zero", 32'(tick_count), 32'd0);
    step();
    cfg_stop = 1'b1;
    step();
    cfg_stop = 1'b0;
    chk_bus("wrap_stop", 1'b1, 1'b0, 3'd1, 16'h0008);
    step();
    chk("wrap_idle", 32'(busy), 32'd0);

    // Get one tick counted, then reset during WR_PH
    start(32'h0000_0020, 1'b1);
    step();
    step();
    step();
    timer_irq = 1'b1;
    step();
    timer_irq = 1'b0;
    chk("pre_rst_count", 32'(tick_count), 32'd1);
    cfg_stop = 1'b1;
    step();
    cfg_stop = 1'b0;
    step();
    start(32'h0000_0020, 1'b1);
    step();
    chk_bus("rst_ph", 1'b1, 1'b0, 3'd3, 16'h0000);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_bus("mid_rst_bus", 1'b0, 1'b0, 3'd0, 16'h0000);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_count", 32'(tick_count), 32'd0);
    step();
    chk_bus("mid_rst_idle", 1'b0, 1'b0, 3'd0, 16'h0000);
    chk("mid_rst_idle_busy", 32'(busy), 32'd0);

`ifdef TIMER_SEQ_SNAPSHOT_EN
    // Snapshot sequence from RUN
    start(32'h0000_0040, 1'b1);
    step();
    step();
    step();
    snap_req = 1'b1;
    step();
    snap_req = 1'b0;
    chk_bus("snap_wr", 1'b1, 1'b0, 3'd4, 16'h0000);
    step();
    chk_bus("snap_rl", 1'b0, 1'b1, 3'd4, 16'h0000);
    step();
    chk_bus("snap_rh", 1'b0, 1'b1, 3'd5, 16'h0000);
    avm_readdata = 16'h1234;
    step();
    chk_bus("snap_cap", 1'b0, 1'b0, 3'd0, 16'h0000);
    avm_readdata = 16'h0002;
    step();
    avm_readdata = 16'h0000;
    chk("snap_valid", 32'(snap_valid), 32'd1);
    chk("snap_value", snap_value, 32'h0002_1234);
    step();
    chk("snap_valid_pulse", 32'(snap_valid), 32'd0);
    chk("snap_busy", 32'(busy), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
